// File: rtl/interleaver_ctrl.sv
// Interleaver memory sequencer: row-order fill and column-order drain, 8 bits per cycle.
// Build option CFG_CHECK_EN: reject illegal rows/cols at start and pulse cfg_err.
module interleaver_ctrl #(
  parameter int ADDR_W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     cfg_rows,
  input  logic [ADDR_W-1:0]     cfg_cols,
  output logic                  busy,
  output logic                  done,
  output logic                  cfg_err,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_data,
  output logic                  mem_write_en,
  output logic [ADDR_W-1:0]     mem_write_addr,
  output logic [7:0]            mem_data_in,
  output logic [8*ADDR_W-1:0]   mem_read_addr,
  input  logic [7:0]            mem_data_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [7:0]            out_data,
  output logic                  out_last
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam logic [ADDR_W-1:0] ZERO  = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] EIGHT = ADDR_W'(8);

  logic [1:0]        state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cfg_err_q, cfg_err_d;
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic [7:0]        out_data_q, out_data_d;
  logic [ADDR_W-1:0] rows_q, rows_d;
  logic [ADDR_W-1:0] cols_q, cols_d;
  logic [ADDR_W-1:0] k_q, k_d;
  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W-1:0] r_q, r_d;
  logic [ADDR_W-1:0] c_q, c_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] off_q [8];
  logic [ADDR_W-1:0] off_d [8];

  logic              cfg_bad_s;
  logic [ADDR_W-1:0] rows_eff_s;
  logic [ADDR_W-1:0] k_s;
  logic              wr_s;
  logic              adv_s;
  logic              last_s;

  // Low row bits are dropped so every counter compare stays reachable even for illegal cfg.
  assign rows_eff_s = {cfg_rows[ADDR_W-1:3], 3'b000};
  assign k_s        = rows_eff_s * cfg_cols;

`ifdef CFG_CHECK_EN
  logic [2*ADDR_W-1:0] k_full_s;
  assign k_full_s  = {{ADDR_W{1'b0}}, cfg_rows} * {{ADDR_W{1'b0}}, cfg_cols};
  assign cfg_bad_s = (cfg_rows == ZERO) || (cfg_rows[2:0] != 3'b000) || (cfg_cols == ZERO) ||
                     (k_full_s > ((2*ADDR_W)'(1) << ADDR_W));
`else
  assign cfg_bad_s = 1'b0;
`endif

  assign wr_s   = in_valid & in_ready_q;
  assign adv_s  = (~out_valid_q | out_ready) & ~out_last_q;
  assign last_s = (c_q == cols_q - ONE) && (r_q == rows_q - EIGHT);

  assign busy           = busy_q;
  assign done           = done_q;
  assign cfg_err        = cfg_err_q;
  assign in_ready       = in_ready_q;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;
  assign out_last       = out_last_q;
  assign mem_write_en   = wr_s;
  assign mem_write_addr = wptr_q;
  assign mem_data_in    = in_data;

  for (genvar g = 0; g < 8; g++) begin : g_lane
    assign mem_read_addr[g*ADDR_W +: ADDR_W] = base_q + off_q[g];
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cfg_err_d   = 1'b0;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;
    rows_d      = rows_q;
    cols_d      = cols_q;
    k_d         = k_q;
    wptr_d      = wptr_q;
    r_d         = r_q;
    c_d         = c_q;
    base_d      = base_q;
    for (int i = 0; i < 8; i++) off_d[i] = off_q[i];

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_bad_s) begin
            cfg_err_d = 1'b1;
          end else begin
            state_d    = S_FILL;
            busy_d     = 1'b1;
            in_ready_d = 1'b1;
            rows_d     = rows_eff_s;
            cols_d     = cfg_cols;
            k_d        = k_s;
            wptr_d     = ZERO;
            r_d        = ZERO;
            c_d        = ZERO;
            base_d     = ZERO;
            for (int i = 0; i < 8; i++) off_d[i] = cfg_cols * ADDR_W'(i);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        if (wr_s) begin
          wptr_d = wptr_q + EIGHT;
          if (wptr_q == k_q - EIGHT) begin
            state_d    = S_DRAIN;
            in_ready_d = 1'b0;
          end else begin
            state_d = S_FILL;
          end
        end else begin
          state_d = S_FILL;
        end
      end
      S_DRAIN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end else if (adv_s) begin
          out_data_d  = mem_data_out;
          out_valid_d = 1'b1;
          out_last_d  = last_s;
          // Column wrap restarts base at the next column; otherwise step down 8 rows.
          if (r_q == rows_q - EIGHT) begin
            r_d    = ZERO;
            c_d    = c_q + ONE;
            base_d = c_q + ONE;
          end else begin
            r_d    = r_q + EIGHT;
            base_d = base_q + (cols_q << 3);
          end
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d     = S_IDLE;
        busy_d      = 1'b0;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
        out_last_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cfg_err_q   <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= 8'h00;
      rows_q      <= ZERO;
      cols_q      <= ZERO;
      k_q         <= ZERO;
      wptr_q      <= ZERO;
      r_q         <= ZERO;
      c_q         <= ZERO;
      base_q      <= ZERO;
      for (int i = 0; i < 8; i++) off_q[i] <= ZERO;
    end else begin
      state_q     <= state_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cfg_err_q   <= cfg_err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      rows_q      <= rows_d;
      cols_q      <= cols_d;
      k_q         <= k_d;
      wptr_q      <= wptr_d;
      r_q         <= r_d;
      c_q         <= c_d;
      base_q      <= base_d;
      for (int i = 0; i < 8; i++) off_q[i] <= off_d[i];
    end
  end

endmodule

// File: tb/tb_interleaver_ctrl.sv
// Directed bench for interleaver_ctrl with a behavioural 8-lane bit memory.
module tb_interleaver_ctrl;
  localparam int AW = 13;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] cfg_rows, cfg_cols;
  logic          busy, done, cfg_err;
  logic          in_valid, in_ready;
  logic [7:0]    in_data;
  logic          mem_write_en;
  logic [AW-1:0] mem_write_addr;
  logic [7:0]    mem_data_in;
  logic [8*AW-1:0] mem_read_addr;
  logic [7:0]    mem_data_out;
  logic          out_valid, out_ready;
  logic [7:0]    out_data;
  logic          out_last;

  int vecs = 0;
  int errs = 0;

  logic        mem_bits [0:(1<<AW)-1];
  logic [7:0]  in_words [0:15];
  logic [7:0]  got_d [$];
  logic        got_l [$];
  logic [AW-1:0] rd_q [$];
  int          first_valid;
  int          stall_bad;
  logic        drain_to;

  interleaver_ctrl #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_rows(cfg_rows), .cfg_cols(cfg_cols),
    .busy(busy), .done(done), .cfg_err(cfg_err),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mem_write_en(mem_write_en), .mem_write_addr(mem_write_addr), .mem_data_in(mem_data_in),
    .mem_read_addr(mem_read_addr), .mem_data_out(mem_data_out),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write_en) begin
      for (int i = 0; i < 8; i++) mem_bits[AW'(mem_write_addr + AW'(i))] <= mem_data_in[i];
    end
  end

  always_comb begin
    mem_data_out = 8'h00;
    for (int i = 0; i < 8; i++) mem_data_out[i] = mem_bits[mem_read_addr[i*AW +: AW]];
  end

  function automatic logic [7:0] exp_word(int cols, int c, int r);
    logic [7:0] v, w;
    int a;
    v = 8'h00;
    for (int i = 0; i < 8; i++) begin
      a = (r + i) * cols + c;
      w = in_words[a / 8];
      v[i] = w[a % 8];
    end
    return v;
  endfunction

  task automatic do_start(input int rows, input int cols);
    cfg_rows = AW'(rows); cfg_cols = AW'(cols); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic do_fill(input int n);
    for (int w = 0; w < n; w++) begin
      in_valid = 1'b1; in_data = in_words[w];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic do_drain(input int stall_at, input int stall_len);
    logic finished, stalled, snap_l;
    logic [7:0] snap_d;
    got_d.delete(); got_l.delete(); rd_q.delete();
    first_valid = -1; stall_bad = 0; finished = 1'b0; stalled = 1'b0;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      if (stall_at >= 0 && !stalled && got_d.size() == stall_at && out_valid === 1'b1) begin
        snap_d = out_data; snap_l = out_last; out_ready = 1'b0;
        repeat (stall_len) begin
          @(posedge clk); #1;
          if (out_valid !== 1'b1 || out_data !== snap_d || out_last !== snap_l) stall_bad++;
        end
        out_ready = 1'b1; stalled = 1'b1;
      end
      rd_q.push_back(mem_read_addr[AW-1:0]);
      if (out_valid === 1'b1 && first_valid < 0) first_valid = cyc;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        got_d.push_back(out_data); got_l.push_back(out_last);
        if (out_last === 1'b1) finished = 1'b1;
      end
      @(posedge clk); #1;
    end
    drain_to = ~finished;
  endtask

  task automatic test_reset;
    rst = 1'b1; repeat (2) @(posedge clk); #1; rst = 1'b0;
    vecs++; if ({busy, done, cfg_err, in_ready, out_valid, out_last} !== 6'b0) begin
      errs++; $display("FAIL reset_flags got %b want 000000", {busy, done, cfg_err, in_ready, out_valid, out_last});
    end
    vecs++; if (out_data !== 8'h00) begin errs++; $display("FAIL reset_data got %h want 00", out_data); end
  endtask

  task automatic test_two_col;
    in_words[0] = 8'h55; in_words[1] = 8'h55;
    do_start(8, 2);
    vecs++; if (busy !== 1'b1 || in_ready !== 1'b1) begin
      errs++; $display("FAIL fill_entry busy=%b in_ready=%b want 1 1", busy, in_ready);
    end
    do_fill(2);
    vecs++; if (in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL drain_entry in_ready=%b out_valid=%b want 0 0", in_ready, out_valid);
    end
    do_drain(-1, 0);
    vecs++; if (drain_to !== 1'b0 || got_d.size() != 2) begin
      errs++; $display("FAIL two_col_count got %0d words timeout=%b want 2", got_d.size(), drain_to);
    end else begin
      vecs++; if (got_d[0] !== 8'hFF || got_l[0] !== 1'b0) begin
        errs++; $display("FAIL two_col_w0 got %h/%b want ff/0", got_d[0], got_l[0]);
      end
      vecs++; if (got_d[1] !== 8'h00 || got_l[1] !== 1'b1) begin
        errs++; $display("FAIL two_col_w1 got %h/%b want 00/1", got_d[1], got_l[1]);
      end
    end
    vecs++; if (first_valid != 1) begin errs++; $display("FAIL first_valid got %0d want 1", first_valid); end
    vecs++; if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL done_pulse done=%b busy=%b out_valid=%b want 1 0 0", done, busy, out_valid);
    end
    @(posedge clk); #1;
    vecs++; if (done !== 1'b0) begin errs++; $display("FAIL done_width got %b want 0", done); end
  endtask

  task automatic test_single_word;
    in_words[0] = 8'hA3;
    do_start(8, 1); do_fill(1); do_drain(-1, 0);
    vecs++; if (drain_to !== 1'b0 || got_d.size() != 1) begin
      errs++; $display("FAIL single_count got %0d words timeout=%b want 1", got_d.size(), drain_to);
    end else begin
      vecs++; if (got_d[0] !== 8'hA3 || got_l[0] !== 1'b1) begin
        errs++; $display("FAIL single_word got %h/%b want a3/1", got_d[0], got_l[0]);
      end
    end
    vecs++; if (done !== 1'b1) begin errs++; $display("FAIL single_done got %b want 1", done); end
  endtask

  task automatic load_16x4;
    in_words[0] = 8'h3C; in_words[1] = 8'hA5; in_words[2] = 8'h0F; in_words[3] = 8'h81;
    in_words[4] = 8'h7E; in_words[5] = 8'hC3; in_words[6] = 8'h18; in_words[7] = 8'hF0;
  endtask

  task automatic test_addr_seq;
    int exp_a [8];
    exp_a = '{0, 32, 1, 33, 2, 34, 3, 35};
    load_16x4();
    do_start(16, 4); do_fill(8);
    vecs++; if (mem_read_addr[2*AW-1:AW] !== AW'(4) || mem_read_addr[8*AW-1:7*AW] !== AW'(28)) begin
      errs++; $display("FAIL lane_stride lane1=%0d lane7=%0d want 4 28",
                       mem_read_addr[2*AW-1:AW], mem_read_addr[8*AW-1:7*AW]);
    end
    do_drain(-1, 0);
    vecs++; if (drain_to !== 1'b0 || got_d.size() != 8 || rd_q.size() < 8) begin
      errs++; $display("FAIL addr_count got %0d words timeout=%b want 8", got_d.size(), drain_to);
    end else begin
      for (int j = 0; j < 8; j++) begin
        vecs++; if (rd_q[j] !== AW'(exp_a[j])) begin
          errs++; $display("FAIL rd_base[%0d] got %0d want %0d", j, rd_q[j], exp_a[j]);
        end
        vecs++; if (got_d[j] !== exp_word(4, j / 2, (j % 2) * 8) || got_l[j] !== (j == 7)) begin
          errs++; $display("FAIL addr_data[%0d] got %h/%b want %h/%b", j, got_d[j], got_l[j],
                           exp_word(4, j / 2, (j % 2) * 8), (j == 7));
        end
      end
    end
  endtask

  task automatic test_stall;
    load_16x4();
    do_start(16, 4); do_fill(8); do_drain(3, 5);
    vecs++; if (stall_bad != 0) begin errs++; $display("FAIL stall_hold got %0d changes want 0", stall_bad); end
    vecs++; if (drain_to !== 1'b0 || got_d.size() != 8) begin
      errs++; $display("FAIL stall_count got %0d words timeout=%b want 8", got_d.size(), drain_to);
    end else begin
      for (int j = 0; j < 8; j++) begin
        vecs++; if (got_d[j] !== exp_word(4, j / 2, (j % 2) * 8)) begin
          errs++; $display("FAIL stall_data[%0d] got %h want %h", j, got_d[j], exp_word(4, j / 2, (j % 2) * 8));
        end
      end
    end
  endtask

  task automatic test_reset_mid_fill;
    load_16x4();
    do_start(16, 4); do_fill(3);
    in_valid = 1'b1; in_data = in_words[3]; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    vecs++; if (busy !== 1'b0 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
      errs++; $display("FAIL rst_mid_fill busy=%b in_ready=%b out_valid=%b want 0 0 0", busy, in_ready, out_valid);
    end
    in_words[0] = 8'h0F; in_words[1] = 8'h33;
    do_start(8, 2); do_fill(2); do_drain(-1, 0);
    vecs++; if (drain_to !== 1'b0 || got_d.size() != 2) begin
      errs++; $display("FAIL rst_restart_count got %0d words timeout=%b want 2", got_d.size(), drain_to);
    end else begin
      vecs++; if (got_d[0] !== 8'h53 || got_d[1] !== 8'h53 || got_l[1] !== 1'b1) begin
        errs++; $display("FAIL rst_restart_data got %h %h last %b want 53 53 1", got_d[0], got_d[1], got_l[1]);
      end
    end
  endtask

`ifdef CFG_CHECK_EN
  task automatic test_cfg_err;
    cfg_rows = AW'(12); cfg_cols = AW'(4); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    vecs++; if (cfg_err !== 1'b1 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errs++; $display("FAIL cfg_err_pulse cfg_err=%b busy=%b in_ready=%b want 1 0 0", cfg_err, busy, in_ready);
    end
    @(posedge clk); #1;
    vecs++; if (cfg_err !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0) begin
      errs++; $display("FAIL cfg_err_after cfg_err=%b busy=%b in_ready=%b want 0 0 0", cfg_err, busy, in_ready);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; start = 1'b0; cfg_rows = '0; cfg_cols = '0;
    in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
    test_reset();
    test_two_col();
    test_single_word();
    test_addr_seq();
    test_stall();
    test_reset_mid_fill();
`ifdef CFG_CHECK_EN
    test_cfg_err();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
